// File: rtl/ext_arb_pkg.sv
// ext_arb_pkg: shared constants, mode codes and round-robin helper for ext_bus_arbiter.
// SIGN_EXT_EN adds the SEXT and SSHL2 mode codes.
package ext_arb_pkg;
  localparam int IN_W = 16;
  localparam int OUT_W = 32;
  localparam int NREQ = 3;
  localparam logic [1:0] REQ_STACK = 2'd0;
  localparam logic [1:0] REQ_PC = 2'd1;
  localparam logic [1:0] REQ_ROM = 2'd2;
  typedef enum logic [2:0] {
    ZEXT = 3'd0,
    SHL2 = 3'd1,
    SHL4 = 3'd2,
    SHL8 = 3'd3,
    SHL16 = 3'd4
`ifdef SIGN_EXT_EN
    , SEXT = 3'd5,
    SSHL2 = 3'd6
`endif
  } ext_mode_t;
  function automatic logic [1:0] rr_next(input logic [1:0] p, input int k);
    return 2'((int'(p) + k) % NREQ);
  endfunction
endpackage

// File: rtl/ext_unit.sv
// ext_unit: widens one requester word to OUT_W according to its mode; SIGN_EXT_EN enables sign modes.
module ext_unit
  import ext_arb_pkg::*;
(
  input  logic [IN_W-1:0]  a,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] y
);
  logic [OUT_W-1:0] zx;
  assign zx = OUT_W'(a);
`ifdef SIGN_EXT_EN
  logic [OUT_W-1:0] sx;
  assign sx = {{(OUT_W-IN_W){a[IN_W-1]}}, a};
`endif
  always_comb begin
    case (mode)
      SHL2:  y = zx << 2;
      SHL4:  y = zx << 4;
      SHL8:  y = zx << 8;
      SHL16: y = zx << 16;
`ifdef SIGN_EXT_EN
      SEXT:  y = sx;
      SSHL2: y = sx << 2;
`endif
      default: y = zx;
    endcase
  end
endmodule

// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter: round-robin share of one widening path among stack/PC/ROM into a valid/ready slot.
// Define SIGN_EXT_EN to enable the sign-extending modes in ext_unit.
module ext_bus_arbiter
  import ext_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [IN_W-1:0]   stack_in,
  input  logic [IN_W-1:0]   pc_in,
  input  logic [IN_W-1:0]   rom_in,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [2:0]        cfg_mode,
  output logic [NREQ-1:0]   gnt,
  output logic [OUT_W-1:0]  out_data,
  output logic [1:0]        out_src,
  output logic              out_valid,
  input  logic              out_ready
);
  logic [1:0] last_q, last_d, win, out_src_q, out_src_d;
  logic out_valid_q, out_valid_d, can_accept, gnt_v;
  logic [OUT_W-1:0] out_data_q, out_data_d, ext_y;
  logic [IN_W-1:0] word;
  ext_mode_t mode_q [NREQ];
  ext_mode_t mode_d [NREQ];
  // Scan from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    can_accept = !out_valid_q || out_ready;
    gnt_v = 1'b0;
    win = last_q;
    for (int k = NREQ; k >= 1; k--)
      if (req[rr_next(last_q, k)]) begin
        gnt_v = 1'b1;
        win = rr_next(last_q, k);
      end
    gnt_v = gnt_v && can_accept && !rst;
    gnt = gnt_v ? 3'b001 << win : '0;
    word = win == REQ_STACK ? stack_in : win == REQ_PC ? pc_in : rom_in;
  end
  ext_unit u_ext (.a(word), .mode(mode_q[win]), .y(ext_y));
  always_comb begin
    last_d = gnt_v ? win : last_q;
    out_valid_d = gnt_v || (out_valid_q && !out_ready);
    out_data_d = gnt_v ? ext_y : out_data_q;
    out_src_d = gnt_v ? win : out_src_q;
    mode_d = mode_q;
    if (cfg_we && cfg_sel != 2'd3) mode_d[cfg_sel] = ext_mode_t'(cfg_mode);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_ROM;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_src_q <= '0;
      mode_q <= '{default: ZEXT};
    end else begin
      last_q <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_src_q <= out_src_d;
      mode_q <= mode_d;
    end
  end
  assign out_data = out_data_q;
  assign out_src = out_src_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_ext_bus_arbiter.sv
// tb_ext_bus_arbiter: directed vector table, reset corner case and random traffic against a reference model.
module tb_ext_bus_arbiter;
  logic clk = 1'b0;
  logic rst, cfg_we, out_valid, out_ready;
  logic [2:0] req, gnt, cfg_mode;
  logic [15:0] stack_in, pc_in, rom_in;
  logic [1:0] cfg_sel, out_src;
  logic [31:0] out_data;
  int checks = 0;
  int errors = 0;
  int m_last, m_src, last_w;
  int m_mode [3];
  bit m_valid;
  logic [31:0] m_data;
`ifdef SIGN_EXT_EN
  localparam logic [31:0] SX = 32'hFFFF8001;
`else
  localparam logic [31:0] SX = 32'h00008001;
`endif
  typedef struct {
    logic [2:0] req; logic [15:0] s, p, r; logic we; logic [1:0] sel; logic [2:0] mode;
    logic rdy; logic [2:0] eg; logic ev; logic [31:0] ed; logic [1:0] es;
  } vec_t;
  vec_t vt [$];

  always #5 clk = ~clk;

  ext_bus_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .stack_in(stack_in), .pc_in(pc_in), .rom_in(rom_in),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .gnt(gnt), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [31:0] widen(input logic [15:0] a, input int m);
    longint v = longint'(a);
`ifdef SIGN_EXT_EN
    longint s = a[15] ? v - 65536 : v;
`endif
    case (m)
      1: v = v * 4;
      2: v = v * 16;
      3: v = v * 256;
      4: v = v * 65536;
`ifdef SIGN_EXT_EN
      5: v = s;
      6: v = s * 4;
`endif
      default: ;
    endcase
    return 32'(v);
  endfunction

  function automatic int winner(input logic [2:0] r);
    for (int k = 1; k <= 3; k++) if (r[(m_last + k) % 3]) return (m_last + k) % 3;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    int w;
    logic [15:0] a;
    #2;
    w = (rst || (m_valid && !out_ready)) ? -1 : winner(req);
    check("model_gnt", 32'(gnt), w < 0 ? 32'd0 : 32'd1 << w);
    @(posedge clk);
    if (rst) begin
      m_last = 2; m_mode = '{0, 0, 0}; m_valid = 0; m_data = 0; m_src = 0;
    end else begin
      if (w >= 0) begin
        a = w == 0 ? stack_in : w == 1 ? pc_in : rom_in;
        m_data = widen(a, m_mode[w]); m_src = w; m_last = w; m_valid = 1;
      end else if (out_ready) m_valid = 0;
      if (cfg_we && cfg_sel != 2'd3) m_mode[cfg_sel] = int'(cfg_mode);
    end
    #1;
    check("model_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid || rst) begin
      check("model_data", out_data, m_data);
      check("model_src", 32'(out_src), 32'(m_src));
    end
    last_w = w;
    @(negedge clk);
  endtask

  task automatic add(input logic [2:0] rq, input logic [15:0] s, p, r, input logic we,
                     input logic [1:0] sel, input logic [2:0] md, input logic rdy,
                     input logic [2:0] eg, input logic ev, input logic [31:0] ed, input logic [1:0] es);
    vec_t v;
    v.req = rq; v.s = s; v.p = p; v.r = r; v.we = we; v.sel = sel; v.mode = md; v.rdy = rdy;
    v.eg = eg; v.ev = ev; v.ed = ed; v.es = es;
    vt.push_back(v);
  endtask

  initial begin
    rst = 1; req = 3'b001; stack_in = 0; pc_in = 0; rom_in = 0;
    cfg_we = 0; cfg_sel = 0; cfg_mode = 0; out_ready = 1;
    m_last = 2; m_mode = '{0, 0, 0}; m_valid = 0; m_data = 0; m_src = 0; last_w = -1;
    @(negedge clk);
    tick();
    tick();
    check("reset_gnt", 32'(gnt), 32'd0);
    rst = 0;
    add(3'b001, 16'hABCD, 0, 0, 0, 0, 0, 1, 3'b001, 1, 32'h0000ABCD, 0);
    add(3'b000, 0, 0, 0, 1, 1, 4, 1, 3'b000, 0, 0, 0);
    add(3'b010, 0, 16'h1234, 0, 0, 0, 0, 1, 3'b010, 1, 32'h12340000, 1);
    add(3'b000, 0, 0, 0, 1, 1, 1, 1, 3'b000, 0, 0, 0);
    add(3'b010, 0, 16'hFFFF, 0, 0, 0, 0, 1, 3'b010, 1, 32'h0003FFFC, 1);
    add(3'b100, 0, 0, 16'h0055, 0, 0, 0, 1, 3'b100, 1, 32'h00000055, 2);
    for (int i = 0; i < 2; i++) begin
      add(3'b111, 16'hABCD, 16'hFFFF, 16'h0055, 0, 0, 0, 1, 3'b001, 1, 32'h0000ABCD, 0);
      add(3'b111, 16'hABCD, 16'hFFFF, 16'h0055, 0, 0, 0, 1, 3'b010, 1, 32'h0003FFFC, 1);
      add(3'b111, 16'hABCD, 16'hFFFF, 16'h0055, 0, 0, 0, 1, 3'b100, 1, 32'h00000055, 2);
    end
    add(3'b001, 16'hABCD, 0, 0, 0, 0, 0, 1, 3'b001, 1, 32'h0000ABCD, 0);
    for (int i = 0; i < 3; i++) add(3'b100, 0, 0, 16'h7E57, 0, 0, 0, 0, 3'b000, 1, 32'h0000ABCD, 0);
    add(3'b100, 0, 0, 16'h7E57, 0, 0, 0, 1, 3'b100, 1, 32'h00007E57, 2);
    add(3'b000, 0, 0, 0, 1, 0, 5, 1, 3'b000, 0, 0, 0);
    add(3'b001, 16'h8001, 0, 0, 0, 0, 0, 1, 3'b001, 1, SX, 0);
    add(3'b001, 16'h0011, 0, 0, 1, 0, 2, 1, 3'b001, 1, 32'h00000011, 0);
    add(3'b001, 16'h0011, 0, 0, 1, 3, 0, 1, 3'b001, 1, 32'h00000110, 0);
    add(3'b000, 0, 0, 0, 1, 0, 3, 1, 3'b000, 0, 0, 0);
    add(3'b001, 16'h1234, 0, 0, 0, 0, 0, 1, 3'b001, 1, 32'h00123400, 0);
    add(3'b000, 0, 0, 0, 1, 2, 7, 1, 3'b000, 0, 0, 0);
    add(3'b100, 0, 0, 16'h8001, 0, 0, 0, 1, 3'b100, 1, 32'h00008001, 2);
    foreach (vt[i]) begin
      req = vt[i].req; stack_in = vt[i].s; pc_in = vt[i].p; rom_in = vt[i].r;
      cfg_we = vt[i].we; cfg_sel = vt[i].sel; cfg_mode = vt[i].mode; out_ready = vt[i].rdy;
      #1;
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].eg));
      tick();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].ev));
      if (vt[i].ev) begin
        check($sformatf("vec%0d_data", i), out_data, vt[i].ed);
        check($sformatf("vec%0d_src", i), 32'(out_src), 32'(vt[i].es));
      end
    end
    cfg_we = 1; cfg_sel = 1; cfg_mode = 4; req = 0; out_ready = 1;
    tick();
    cfg_we = 0; req = 3'b010; pc_in = 16'h1234;
    tick();
    check("pre_rst_data", out_data, 32'h12340000);
    out_ready = 0;
    tick();
    tick();
    rst = 1;
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    rst = 0; out_ready = 1;
    #1;
    check("post_rst_gnt", 32'(gnt), 32'b010);
    tick();
    check("post_rst_data", out_data, 32'h00001234);
    check("post_rst_src", 32'(out_src), 32'd1);
    for (int c = 0; c < 500; c++) begin
      if (last_w >= 0) req[last_w] = 1'b0;
      for (int b = 0; b < 3; b++)
        if (!req[b] && $urandom_range(1) == 1) begin
          req[b] = 1'b1;
          if (b == 0) stack_in = 16'($urandom);
          else if (b == 1) pc_in = 16'($urandom);
          else rom_in = 16'($urandom);
        end
      out_ready = $urandom_range(3) != 0;
      cfg_we = $urandom_range(3) == 0;
      cfg_sel = 2'($urandom_range(3));
      cfg_mode = 3'($urandom_range(7));
      rst = $urandom_range(63) == 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ext_bus_arbiter.md
Name: ext_bus_arbiter

Overview:
- Shares one 32-bit widened-operand path between three 16-bit requesters: stack (0), PC (1), ROM (2).
- Round-robin arbitration, one grant per cycle.
- Widens the winner's word according to a per-requester configured mode: zero-extend, or left-shift with zero fill.
- Places the result in a registered output slot with valid/ready backpressure.
- Sits between stack/PC/ROM sources and the 32-bit datapath; replaces the fixed per-source extenders.

Parameters:
- IN_W, 16, requester word width.
- OUT_W, 32, output word width; must be >= IN_W+16.
- NREQ, 3, requester count; fixed at 3 for this revision.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  3  request per source: bit0 stack, bit1 PC, bit2 ROM. Held high until granted.
- stack_in  in  16  stack word; held stable while req[0] is high.
- pc_in  in  16  PC word; held stable while req[1] is high.
- rom_in  in  16  ROM word; held stable while req[2] is high.
- cfg_we  in  1  mode-table write strobe.
- cfg_sel  in  2  requester index to configure; value 3 is ignored.
- cfg_mode  in  3  mode code to write.
- gnt  out  3  one-hot grant, combinational. Indicates the word is captured at this clock edge.
- out_data  out  32  widened word.
- out_src  out  2  index of the requester that produced out_data.
- out_valid  out  1  output slot full.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.

Behaviour:
- Reset:
  - out_valid=0, out_data=0, out_src=0, gnt=0.
  - RR pointer last=2, so stack has top priority first.
  - All three modes = ZEXT.
  - Reset mid-transfer discards the slot contents. Requesters keep their req asserted and are re-arbitrated after reset.
- Slot FSM:
  - States: EMPTY and FULL, encoded by out_valid.
  - can_accept = !out_valid || out_ready.
  - EMPTY -> FULL when a grant is issued.
  - FULL -> EMPTY when out_ready is high and no grant is issued.
  - FULL -> FULL (reload) when out_ready is high and a grant is issued; one transfer per cycle throughput.
  - FULL holds out_data/out_src unchanged while out_ready=0.
- Grant rule:
  - gnt nonzero only if can_accept && |req.
  - Search order is last+1, last+2, last+3 (mod 3); the first requester with req set wins.
  - last updates to the winner on a grant.
  - At most one gnt bit high per cycle.
  - gnt never asserts for a requester whose req is low.
- Latency: req with an empty slot gives gnt in the same cycle; out_valid rises on the next edge (1 cycle).
- Mode codes (unsigned, zero fill, result width 32):
  - 0 ZEXT: {16'h0, a}
  - 1 SHL2: {14'h0, a, 2'b0}
  - 2 SHL4: {12'h0, a, 4'b0}
  - 3 SHL8: {8'h0, a, 8'b0}
  - 4 SHL16: {a, 16'h0}
  - 5-7 reserved, behave as ZEXT.
- Config:
  - When cfg_we=1 and cfg_sel<3, mode[cfg_sel] <= cfg_mode.
  - A grant in the same cycle as a write to its own mode uses the old mode; the new mode applies from the next cycle.
  - cfg_sel=3 writes nothing.
- Fairness: with all three requesting continuously and out_ready=1, grants rotate 0,1,2,0,... with no starvation. A single requester gets back-to-back grants.

Optional Feature:
- Macro SIGN_EXT_EN.
- When defined:
  - Adds mode 5 SEXT: {{16{a[15]}}, a}.
  - Adds mode 6 SSHL2: {{14{a[15]}}, a, 2'b0}.
  - Mode 7 remains reserved and behaves as ZEXT.
- When undefined: modes 5-7 all behave as ZEXT, and no sign logic is generated.

Decomposition:
- Package ext_arb_pkg holds:
  - Requester index constants REQ_STACK=0, REQ_PC=1, REQ_ROM=2.
  - Mode code enum ext_mode_t (3 bits) with ZEXT..SHL16, plus SEXT/SSHL2 under SIGN_EXT_EN.
  - Width constants IN_W and OUT_W.
- Sub-module ext_unit: combinational. Takes the 16-bit word and ext_mode_t, produces the 32-bit result. Instantiated once, on the granted word's mux output.
- Arbiter, mode table and output slot live in the top module.

Test Plan:
- Reset, then req=3'b001, stack_in=16'hABCD, mode ZEXT, out_ready=1 -> gnt=001 in the same cycle; next cycle out_valid=1, out_data=32'h0000ABCD, out_src=0.
- cfg_sel=1, cfg_mode=4; then req=3'b010, pc_in=16'h1234 -> out_data=32'h12340000. Repeat with mode 1 and pc_in=16'hFFFF -> 32'h0003FFFC.
- req=3'b111 held with out_ready=1 for 6 cycles -> gnt sequence 001,010,100,001,010,100; out_src sequence 0,1,2,0,1,2.
- out_valid=1 with out_ready=0 for 3 cycles while req=3'b100 -> gnt=000 and out_data stable throughout. Raise out_ready -> gnt=100 in that cycle, and the ROM word appears on the next edge.
- Mid-stall, assert rst for 1 cycle -> out_valid=0, out_data=0, modes reset to ZEXT. The held req=3'b010 gets granted first after reset, with stack not requesting.
- With SIGN_EXT_EN: mode 5, stack_in=16'h8001 -> 32'hFFFF8001. Without the macro: the same stimulus -> 32'h00008001.
